// File: rtl/alu_sequencer.sv
// Single-transaction sequencer in front of a combinational ALU with registered flags.
// Compare ops take an extra cycle so the ALU's flag register can settle before capture.
module alu_sequencer #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned OP_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_WIDTH-1:0]  req_op,
  input  logic [WORD_SIZE-1:0] req_a,
  input  logic [WORD_SIZE-1:0] req_b,
  input  logic [3:0]           req_tag,
  output logic [OP_WIDTH-1:0]  alu_com,
  output logic [WORD_SIZE-1:0] alu_in0,
  output logic [WORD_SIZE-1:0] alu_in1,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_carry,
  input  logic                 alu_sign,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic [2:0]           rsp_flags,
  output logic [3:0]           rsp_tag,
  output logic                 rsp_err
);

  localparam logic [OP_WIDTH-1:0] ALU_OP_THA_WORD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_OP_DIV      = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALU_OP_MOD      = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALU_OP_CMP      = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] ALU_OP_CGE      = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] ALU_OP_CGT      = OP_WIDTH'(11);

  typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

  state_t                 state, state_n;
  logic [OP_WIDTH-1:0]    alu_com_n;
  logic [WORD_SIZE-1:0]   alu_in0_n, alu_in1_n, rsp_data_n;
  logic [2:0]             rsp_flags_n, alu_flags;
  logic [3:0]             rsp_tag_n;
  logic                   rsp_err_n, accept, div_zero, exec_cmp;

  // Ready can complete a pending response and take a new request on the same edge.
  assign req_ready = (state == IDLE && !rst) || (state == RESP && rsp_ready);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign div_zero  = (req_op == ALU_OP_DIV || req_op == ALU_OP_MOD) && (req_b == '0);
  assign exec_cmp  = (alu_com == ALU_OP_CMP) || (alu_com == ALU_OP_CGE) || (alu_com == ALU_OP_CGT);
  assign alu_flags = {alu_carry, alu_sign, alu_zero};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_com   <= ALU_OP_THA_WORD;
      alu_in0   <= '0;
      alu_in1   <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      alu_com   <= alu_com_n;
      alu_in0   <= alu_in0_n;
      alu_in1   <= alu_in1_n;
      rsp_data  <= rsp_data_n;
      rsp_flags <= rsp_flags_n;
      rsp_tag   <= rsp_tag_n;
      rsp_err   <= rsp_err_n;
    end
  end

  // ALU command is only non-idle during the single EXEC cycle.
  always_comb begin
    state_n     = state;
    alu_com_n   = ALU_OP_THA_WORD;
    alu_in0_n   = '0;
    alu_in1_n   = '0;
    rsp_data_n  = rsp_data;
    rsp_flags_n = rsp_flags;
    rsp_tag_n   = rsp_tag;
    rsp_err_n   = rsp_err;

    case (state)
      EXEC: begin
        rsp_data_n = alu_out;
        if (exec_cmp) begin
          state_n = FLAG;
        end else begin
          rsp_flags_n = alu_flags;
          state_n     = RESP;
        end
      end
      FLAG: begin
        rsp_flags_n = alu_flags;
        state_n     = RESP;
      end
      RESP: begin
        if (rsp_ready && !req_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      rsp_tag_n = req_tag;
      if (div_zero) begin
        rsp_err_n   = 1'b1;
        rsp_data_n  = '1;
        rsp_flags_n = alu_flags;
        state_n     = RESP;
      end else begin
        rsp_err_n = 1'b0;
        alu_com_n = req_op;
        alu_in0_n = req_a;
        alu_in1_n = req_b;
        state_n   = EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub with registered compare flags, directed plus
// randomized transactions checked against a transaction-level reference model.
module tb_alu_sequencer;

  localparam logic [4:0] OP_THA = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;
  localparam logic [4:0] OP_MOD = 5'd5;
  localparam logic [4:0] OP_CMP = 5'd9;
  localparam logic [4:0] OP_CGE = 5'd10;
  localparam logic [4:0] OP_CGT = 5'd11;
  localparam logic [4:0] OP_UNK = 5'd20;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [4:0]  req_op, alu_com;
  logic [31:0] req_a, req_b, alu_in0, alu_in1, alu_out, rsp_data;
  logic [3:0]  req_tag, rsp_tag;
  logic [2:0]  rsp_flags, alu_flags;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  model_flags;
  logic [31:0] exp_data;
  logic [2:0]  exp_flags;
  logic [3:0]  exp_tag;
  logic        exp_err;

  alu_sequencer #(.WORD_SIZE(32), .OP_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_com(alu_com), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_out(alu_out), .alu_carry(alu_flags[2]), .alu_sign(alu_flags[1]), .alu_zero(alu_flags[0]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return 32'(a * b);
      OP_DIV:  return (b != 0) ? a / b : 32'hFFFF_FFFF;
      OP_MOD:  return (b != 0) ? a % b : 32'hFFFF_FFFF;
      OP_CMP:  return a - b;
      OP_CGE, OP_CGT: return 32'd0;
      default: return a ^ b ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    case (op)
      OP_CMP:  return {a < b, diff[31], a == b};
      OP_CGE:  return {a >= b, !(a >= b), 1'b1};
      default: return {a > b, !(a > b), 1'b1};
    endcase
  endfunction

  // ALU stub: combinational result, flags registered on the edge ending a compare cycle.
  always_comb alu_out = ref_result(alu_com, alu_in0, alu_in1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_flags <= 3'b000;
    else if (alu_com == OP_CMP || alu_com == OP_CGE || alu_com == OP_CGT)
      alu_flags <= ref_flags(alu_com, alu_in0, alu_in1);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_idle_outputs();
    check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    check("alu_com_idle", 64'(alu_com), 64'(OP_THA));
    check("alu_in0_idle", 64'(alu_in0), 64'd0);
    check("alu_in1_idle", 64'(alu_in1), 64'd0);
  endtask

  // Issue one request (called at a negedge) and wait for its response.
  task automatic do_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input bit chain);
    bit dz, cmp;
    int lat, want;
    dz  = (op == OP_DIV || op == OP_MOD) && (b == 0);
    cmp = (op == OP_CMP || op == OP_CGE || op == OP_CGT);
    exp_tag = tag;
    exp_err = dz;
    if (dz) begin
      exp_data  = 32'hFFFF_FFFF;
      exp_flags = model_flags;
      want      = 1;
    end else begin
      exp_data = ref_result(op, a, b);
      if (cmp) model_flags = ref_flags(op, a, b);
      exp_flags = model_flags;
      want      = cmp ? 3 : 2;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    rsp_ready = chain;
    #1;
    check("req_ready_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        if (dz) begin
          check("alu_com_divzero", 64'(alu_com), 64'(OP_THA));
          check("alu_in0_divzero", 64'(alu_in0), 64'd0);
        end else begin
          check("alu_com_exec", 64'(alu_com), 64'(op));
          check("alu_in0_exec", 64'(alu_in0), 64'(a));
          check("alu_in1_exec", 64'(alu_in1), 64'(b));
        end
      end else begin
        check("alu_com_after_exec", 64'(alu_com), 64'(OP_THA));
      end
    end while (!rsp_valid && lat < 8);
    check("latency", 64'(lat), 64'(want));
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_flags", 64'(rsp_flags), 64'(exp_flags));
    check("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
  endtask

  task automatic hold_rsp(input int n);
    repeat (n) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data", 64'(rsp_data), 64'(exp_data));
      check("hold_flags", 64'(rsp_flags), 64'(exp_flags));
      check("hold_tag", 64'(rsp_tag), 64'(exp_tag));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    #1;
    check("req_ready_release", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_idle_outputs();
    check("req_ready_idle", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [4:0] ops [9];
    logic [31:0] ra, rb;
    bit pending;
    ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_CGE, OP_CGT, OP_UNK};
    model_flags = 3'b000;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = OP_THA; req_a = '0; req_b = '0; req_tag = '0;

    #2;
    check("req_ready_in_reset", 64'(req_ready), 64'd0);
    check_idle_outputs();
    check("rsp_data_reset", 64'(rsp_data), 64'd0);
    check("rsp_flags_reset", 64'(rsp_flags), 64'd0);
    check("rsp_tag_reset", 64'(rsp_tag), 64'd0);
    check("rsp_err_reset", 64'(rsp_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("req_ready_after_reset", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Directed cases
    do_req(OP_ADD, 32'd5, 32'd7, 4'd3, 1'b0);  release_rsp();
    do_req(OP_CGE, 32'd9, 32'd4, 4'd1, 1'b0);  release_rsp();
    do_req(OP_CGT, 32'd4, 32'd4, 4'd2, 1'b0);  release_rsp();
    do_req(OP_CMP, 32'd4, 32'd4, 4'd4, 1'b0);  release_rsp();
    do_req(OP_DIV, 32'd10, 32'd0, 4'd7, 1'b0); release_rsp();
    do_req(OP_UNK, 32'h1234, 32'h00FF, 4'd9, 1'b0); release_rsp();
    do_req(OP_SUB, 32'd3, 32'd5, 4'd6, 1'b0);
    hold_rsp(4);
    do_req(OP_MUL, 32'd6, 32'd7, 4'd8, 1'b1);
    release_rsp();

    // Reset while a compare sits in FLAG
    req_valid = 1'b1; req_op = OP_CMP; req_a = 32'd3; req_b = 32'd8; req_tag = 4'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_flags = 3'b000;
    #1;
    check_idle_outputs();
    check("req_ready_mid_reset", 64'(req_ready), 64'd0);
    check("rsp_data_mid_reset", 64'(rsp_data), 64'd0);
    check("rsp_tag_mid_reset", 64'(rsp_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("req_ready_post_reset", 64'(req_ready), 64'd1);
    check("rsp_valid_post_reset", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    do_req(OP_ADD, 32'd1, 32'd1, 4'd2, 1'b0); release_rsp();

    // Randomized transactions, sometimes chained onto a pending response
    pending = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      bit chain;
      op = ops[$urandom_range(0, 8)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? ra : $urandom);
      chain = pending && ($urandom_range(0, 1) == 1);
      if (pending && !chain) release_rsp();
      do_req(op, ra, rb, 4'($urandom_range(0, 15)), chain);
      hold_rsp($urandom_range(0, 2));
      pending = 1'b1;
    end
    if (pending) release_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
